// File: rtl/spi_cfg_master.sv
// SPI write master for the config register file.
// Two requesters, round-robin; each write is an address frame then a data frame.
module spi_cfg_master #(
  parameter int CLK_DIV  = 4,
  parameter int NCS_GAP  = 8,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       done_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  localparam int MAXC = (CLK_DIV > NCS_GAP) ? CLK_DIV : NCS_GAP;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] DIV_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_L = CW'(NCS_GAP - 1);
  localparam logic [4:0] MAXA =
    (MAX_ADDR > 15) ? 5'd15 : 5'(MAX_ADDR);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic            r_hi;
  logic            r_frame;
  logic [3:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_last;
  logic            r_rej;

  logic            r_sclk;
  logic            r_copi;
  logic            r_ncs;
  logic            r_rdy0;
  logic            r_rdy1;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_done_id;

  state_t          w_nxt;
  logic [CW-1:0]   w_cnt;
  logic [2:0]      w_bit;
  logic            w_hi;
  logic            w_frame;
  logic [3:0]      w_addr;
  logic [7:0]      w_data;
  logic            w_last;
  logic            w_fin;
  logic            w_idle;
  logic            w_pick;
  logic            w_grant;
  logic            w_bad;
  logic [3:0]      w_sel_addr;
  logic [7:0]      w_sel_data;
  logic [7:0]      w_byte;

  logic            w_sclk_d;
  logic            w_copi_d;
  logic            w_ncs_d;
  logic            w_rdy0_d;
  logic            w_rdy1_d;
  logic            w_busy_d;
  logic            w_done_d;
  logic            w_err_d;
  logic            w_did_d;

  assign w_last = (r_cnt == ((r_state == S_GAP) ? GAP_L : DIV_L));
  assign w_fin  = (r_state == S_GAP) && r_frame && w_last;
  // Last data-frame gap cycle arbitrates like IDLE: no dead cycle between writes.
  assign w_idle = (r_state == S_IDLE) || w_fin;

  assign w_pick = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_grant = w_idle && !r_rej && (req0_valid || req1_valid);
  assign w_sel_addr = w_pick ? req1_addr : req0_addr;
  assign w_sel_data = w_pick ? req1_data : req0_data;
  assign w_bad = {1'b0, w_sel_addr} > MAXA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
      r_frame <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_last  <= 1'b1;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_hi    <= w_hi;
      r_frame <= w_frame;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_last  <= w_grant ? w_pick : r_last;
      r_rej   <= w_grant && w_bad;
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_cnt   = r_cnt + CW'(1);
    w_bit   = r_bit;
    w_hi    = r_hi;
    w_frame = r_frame;
    w_addr  = r_addr;
    w_data  = r_data;
    if (w_idle) begin
      w_nxt = S_IDLE;
      w_cnt = '0;
      if (w_grant) begin
        w_addr = w_sel_addr;
        w_data = w_sel_data;
        if (!w_bad) begin
          w_nxt   = S_LEAD;
          w_frame = 1'b0;
        end
      end
    end else begin
      unique case (r_state)
        S_LEAD: begin
          if (w_last) begin
            w_nxt = S_SHIFT;
            w_cnt = '0;
            w_hi  = 1'b0;
            w_bit = '0;
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            w_cnt = '0;
            if (!r_hi) begin
              w_hi = 1'b1;
            end else if (r_bit == 3'd7) begin
              w_nxt = S_TRAIL;
            end else begin
              w_hi  = 1'b0;
              w_bit = r_bit + 3'd1;
            end
          end
        end
        S_TRAIL: begin
          if (w_last) begin
            w_nxt = S_GAP;
            w_cnt = '0;
          end
        end
        S_GAP: begin
          if (w_last) begin
            w_nxt   = S_LEAD;
            w_frame = 1'b1;
            w_cnt   = '0;
          end
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  assign w_byte = w_frame ? w_data : {4'b1000, w_addr};

  always_comb begin
    w_ncs_d  = !((w_nxt == S_LEAD) || (w_nxt == S_SHIFT) ||
                 (w_nxt == S_TRAIL));
    w_sclk_d = (w_nxt == S_SHIFT) && w_hi;
    w_copi_d = r_copi;
    if (w_nxt == S_LEAD) begin
      w_copi_d = w_byte[7];
    end else if (w_nxt == S_SHIFT) begin
      w_copi_d = w_byte[3'd7 - w_bit];
    end
    w_rdy0_d = w_grant && !w_pick;
    w_rdy1_d = w_grant && w_pick;
    w_busy_d = (w_nxt != S_IDLE) || w_grant;
    w_done_d = w_fin;
    w_err_d  = r_rej;
    w_did_d  = (w_fin || r_rej) ? r_last : r_done_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk    <= 1'b0;
      r_copi    <= 1'b0;
      r_ncs     <= 1'b1;
      r_rdy0    <= 1'b0;
      r_rdy1    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_sclk    <= w_sclk_d;
      r_copi    <= w_copi_d;
      r_ncs     <= w_ncs_d;
      r_rdy0    <= w_rdy0_d;
      r_rdy1    <= w_rdy1_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      r_done_id <= w_did_d;
    end
  end

  assign sclk       = r_sclk;
  assign copi       = r_copi;
  assign ncs        = r_ncs;
  assign req0_ready = r_rdy0;
  assign req1_ready = r_rdy1;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign done_id    = r_done_id;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: timeline model, SPI peripheral decoder,
// directed writes on a default instance and a CLK_DIV=6/NCS_GAP=4 instance.
module tb_spi_cfg_master;

  localparam int D = 4;
  localparam int G = 8;
  localparam int F = 18 * D + G;
  localparam int MAXA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_v0 = 0, a_v1 = 0;
  logic [3:0] a_a0 = 0, a_a1 = 0;
  logic [7:0] a_d0 = 0, a_d1 = 0;
  logic a_r0, a_r1, a_sclk, a_copi, a_ncs;
  logic a_busy, a_done, a_err, a_did;

  logic       b_v0 = 0;
  logic [3:0] b_a0 = 0;
  logic [7:0] b_d0 = 0;
  logic b_r0, b_r1, b_sclk, b_copi, b_ncs;
  logic b_busy, b_done, b_err, b_did;

  spi_cfg_master u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_addr(a_a0),
    .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_addr(a_a1),
    .req1_data(a_d1), .req1_ready(a_r1),
    .sclk(a_sclk), .copi(a_copi), .ncs(a_ncs),
    .busy(a_busy), .done(a_done), .err(a_err),
    .done_id(a_did)
  );

  spi_cfg_master #(.CLK_DIV(6), .NCS_GAP(4), .MAX_ADDR(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_addr(b_a0),
    .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(1'b0), .req1_addr(4'h0),
    .req1_data(8'h00), .req1_ready(b_r1),
    .sclk(b_sclk), .copi(b_copi), .ncs(b_ncs),
    .busy(b_busy), .done(b_done), .err(b_err),
    .done_id(b_did)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } req_t;
  req_t q0[$];
  req_t q1[$];

  // requester driver: hold a request until its ready pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_r0 && q0.size() > 0) void'(q0.pop_front());
      if (a_r1 && q1.size() > 0) void'(q1.pop_front());
    end
    a_v0 = (q0.size() > 0);
    if (a_v0) begin
      a_a0 = q0[0].a;
      a_d0 = q0[0].d;
    end
    a_v1 = (q1.size() > 0);
    if (a_v1) begin
      a_a1 = q1[0].a;
      a_d1 = q1[0].d;
    end
  end

  // timeline model of instance A
  logic m_act = 0, m_last = 1, m_rej = 0;
  logic m_id = 0, m_rid = 0;
  int   m_k = 0;
  logic [7:0] m_b0 = 0, m_b1 = 0;
  logic e_sclk = 0, e_copi = 0, e_ncs = 1;
  logic e_r0 = 0, e_r1 = 0, e_busy = 0;
  logic e_done = 0, e_err = 0, e_did = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic fin, grant, pick, nrej;
    logic [3:0] ad;
    logic [7:0] da, bt;
    int j, p;
    if (!rst_n) begin
      m_act = 0; m_k = 0; m_last = 1; m_rej = 0;
      e_sclk = 0; e_copi = 0; e_ncs = 1;
      e_r0 = 0; e_r1 = 0; e_busy = 0;
      e_done = 0; e_err = 0; e_did = 0;
    end else begin
      fin = m_act && (m_k == 2 * F - 1);
      e_done = fin;
      e_err = m_rej;
      if (fin) e_did = m_id;
      else if (m_rej) e_did = m_rid;
      if (m_act) m_k++;
      if (fin) m_act = 0;
      grant = !m_act && !m_rej && (a_v0 || a_v1);
      nrej = 0;
      e_r0 = 0;
      e_r1 = 0;
      if (grant) begin
        pick = (a_v0 && a_v1) ? !m_last : a_v1;
        m_last = pick;
        e_r0 = !pick;
        e_r1 = pick;
        ad = pick ? a_a1 : a_a0;
        da = pick ? a_d1 : a_d0;
        if (ad > MAXA) begin
          nrej = 1;
          m_rid = pick;
        end else begin
          m_act = 1;
          m_k = 0;
          m_id = pick;
          m_b0 = {4'h8, ad};
          m_b1 = da;
        end
      end
      m_rej = nrej;
      e_busy = m_act || m_rej;
      e_ncs = 1;
      e_sclk = 0;
      if (m_act) begin
        j = m_k % F;
        p = j / D;
        bt = (m_k >= F) ? m_b1 : m_b0;
        if (j < 18 * D) begin
          e_ncs = 0;
          e_sclk = (p >= 2 && p <= 16 && p % 2 == 0);
          if (p == 0) e_copi = bt[7];
          else if (p <= 16) e_copi = bt[7 - (p - 1) / 2];
          else e_copi = bt[0];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("sclk", a_sclk, e_sclk);
    chk("copi", a_copi, e_copi);
    chk("ncs", a_ncs, e_ncs);
    chk("ready0", a_r0, e_r0);
    chk("ready1", a_r1, e_r1);
    chk("busy", a_busy, e_busy);
    chk("done", a_done, e_done);
    chk("err", a_err, e_err);
    chk("done_id", a_did, e_did);
  end

  // SPI peripheral decoder for both instances
  logic [7:0] p_reg[2][16] = '{default: 8'h00};
  int         p_wc[2] = '{0, 0};
  logic [7:0] sh[2] = '{0, 0};
  int         nb[2] = '{0, 0};
  logic       pend[2] = '{0, 0};
  logic [3:0] pa[2] = '{0, 0};
  logic       ps_sclk[2] = '{0, 0};
  logic       ps_ncs[2] = '{1, 1};
  int         byte_log[$];

  always @(negedge clk) begin : periph
    logic s[2], n[2], c[2];
    s[0] = a_sclk; n[0] = a_ncs; c[0] = a_copi;
    s[1] = b_sclk; n[1] = b_ncs; c[1] = b_copi;
    for (int i = 0; i < 2; i++) begin
      if (s[i] && !ps_sclk[i]) begin
        chk("rise_in_frame", n[i], 1'b0);
        sh[i] = {sh[i][6:0], c[i]};
        nb[i]++;
      end
      if (!n[i] && ps_ncs[i]) nb[i] = 0;
      if (n[i] && !ps_ncs[i]) begin
        if (rst_n) chk("bits_per_frame", nb[i], 8);
        if (nb[i] == 8) begin
          if (i == 0) byte_log.push_back(int'(sh[i]));
          if (!pend[i]) begin
            if (sh[i][7]) begin
              pend[i] = 1;
              pa[i] = sh[i][3:0];
            end
          end else begin
            p_reg[i][pa[i]] = sh[i];
            p_wc[i]++;
            pend[i] = 0;
          end
        end else begin
          pend[i] = 0;
        end
        nb[i] = 0;
      end
      ps_sclk[i] = s[i];
      ps_ncs[i] = n[i];
    end
  end

  int acc_cyc[$], acc_id[$], done_cyc[$], done_ids[$];
  int err_cyc[$], err_ids[$];

  always @(negedge clk) begin
    if (a_r0 || a_r1) begin
      acc_cyc.push_back(cyc);
      acc_id.push_back(int'(a_r1));
    end
    if (a_done) begin
      done_cyc.push_back(cyc);
      done_ids.push_back(int'(a_did));
    end
    if (a_err) begin
      err_cyc.push_back(cyc);
      err_ids.push_back(int'(a_did));
    end
  end

  // instance B half-period and inter-frame gap timing
  logic pb_sclk = 0, pb_ncs = 1, b_fok = 0;
  int b_rise = 0, b_fall = 0, b_nrise = 0, b_nf = 0;

  always @(negedge clk) begin
    if (b_sclk && !pb_sclk) begin
      if (b_fok) chk("b_sclk_low", cyc - b_fall, 6);
      b_rise = cyc;
    end
    if (!b_sclk && pb_sclk) begin
      chk("b_sclk_high", cyc - b_rise, 6);
      b_fall = cyc;
      b_fok = 1;
    end
    if (!b_ncs && pb_ncs) begin
      if (b_nf % 2 == 1) chk("b_ncs_gap", cyc - b_nrise, 4);
      b_nf++;
      b_fok = 0;
    end
    if (b_ncs && !pb_ncs) b_nrise = cyc;
    pb_sclk = b_sclk;
    pb_ncs = b_ncs;
  end

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete();
    done_cyc.delete(); done_ids.delete();
    err_cyc.delete(); err_ids.delete();
    byte_log.delete();
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !a_busy && !a_r0 &&
          !a_r1) break;
    end
    if (i == lim) chk({"timeout_", tag}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
  endtask

  int t0, wc, lim;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ncs", a_ncs, 1);
    chk("rst_sclk", a_sclk, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done_id", a_did, 0);
    #2 rst_n = 1;

    clear_logs();
    q0.push_back('{4'h0, 8'hA5});
    wait_idle(500, "t1");
    chk("t1_nbytes", byte_log.size(), 2);
    chk("t1_addr_byte", qget(byte_log, 0), 32'h80);
    chk("t1_data_byte", qget(byte_log, 1), 32'hA5);
    chk("t1_latency", qget(done_cyc, 0) - qget(acc_cyc, 0), 160);
    chk("t1_done_id", qget(done_ids, 0), 0);
    chk("t1_reg0", p_reg[0][0], 8'hA5);

    do_reset();
    clear_logs();
    q0.push_back('{4'h4, 8'h40});
    q1.push_back('{4'h2, 8'h0F});
    wait_idle(1000, "t2");
    chk("t2_grant0", qget(acc_id, 0), 0);
    chk("t2_grant1", qget(acc_id, 1), 1);
    chk("t2_did0", qget(done_ids, 0), 0);
    chk("t2_did1", qget(done_ids, 1), 1);
    chk("t2_b2b", qget(acc_cyc, 1), qget(done_cyc, 0));
    chk("t2_reg4", p_reg[0][4], 8'h40);
    chk("t2_reg2", p_reg[0][2], 8'h0F);

    clear_logs();
    q0.push_back('{4'h3, 8'h11});
    q0.push_back('{4'h1, 8'h22});
    q1.push_back('{4'h0, 8'h33});
    q1.push_back('{4'h2, 8'h44});
    wait_idle(2000, "t3");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_did%0d", i), qget(done_ids, i), i % 2);
    chk("t3_reg3", p_reg[0][3], 8'h11);
    chk("t3_reg0", p_reg[0][0], 8'h33);
    chk("t3_reg2", p_reg[0][2], 8'h44);

    clear_logs();
    wc = p_wc[0];
    q1.push_back('{4'h7, 8'h77});
    wait_idle(100, "t4");
    chk("t4_ready_id", qget(acc_id, 0), 1);
    chk("t4_err_next", qget(err_cyc, 0), qget(acc_cyc, 0) + 1);
    chk("t4_err_id", qget(err_ids, 0), 1);
    chk("t4_no_done", done_cyc.size(), 0);
    chk("t4_no_write", p_wc[0], wc);

    clear_logs();
    q0.push_back('{4'h3, 8'h99});
    for (lim = 0; lim < 100 && acc_cyc.size() == 0; lim++)
      @(negedge clk);
    if (acc_cyc.size() == 0) chk("timeout_t5_acc", 0, 1);
    t0 = qget(acc_cyc, 0) + F + 6 * D;
    for (lim = 0; lim < 400 && cyc < t0; lim++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_ncs_async", a_ncs, 1);
    chk("t5_sclk_async", a_sclk, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    chk("t5_reg3_kept", p_reg[0][3], 8'h11);
    chk("t5_no_write", p_wc[0], wc);
    q0.push_back('{4'h1, 8'h3C});
    wait_idle(500, "t5");
    chk("t5_reg1", p_reg[0][1], 8'h3C);

    @(negedge clk);
    b_v0 = 1; b_a0 = 4'h4; b_d0 = 8'h5A;
    for (lim = 0; lim < 50; lim++) begin
      @(negedge clk);
      if (b_r0) break;
    end
    if (lim == 50) chk("timeout_t6_acc", 0, 1);
    t0 = cyc;
    b_v0 = 0;
    for (lim = 0; lim < 400; lim++) begin
      @(negedge clk);
      if (b_done) break;
    end
    if (lim == 400) chk("timeout_t6_done", 0, 1);
    chk("t6_latency", cyc - t0, 224);
    repeat (3) @(negedge clk);
    chk("t6_reg4", p_reg[1][4], 8'h5A);
    chk("t6_writes", p_wc[1], 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
